// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: pulses PLL reset, waits for a synchronized and stable lock, then releases
// the downstream reset. Lock timeouts are retried until the budget runs out, which raises a sticky fault.
module pll_lock_sequencer #(
    parameter int RST_CYCLES     = 16,
    parameter int STABLE_CYCLES  = 1024,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_cnt
);

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_STABILIZE,
        S_RUN,
        S_FAULT
    } state_t;

    localparam logic [15:0] RST_LAST     = 16'(RST_CYCLES - 1);
    localparam logic [15:0] STABLE_LAST  = 16'(STABLE_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  RETRY_LIMIT  = 4'(MAX_RETRIES);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  retry_q, retry_d;
    logic [3:0]  retry_inc;
    logic        sync1_q, lk_q;
    logic        pll_rst_q, pll_rst_d;
    logic        sys_rst_n_q, sys_rst_n_d;
    logic        ready_q, ready_d;
    logic        fault_q, fault_d;

    assign retry_inc = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        if (relock_req) begin
            state_d = S_PLL_RST;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                S_PLL_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lk_q) begin
                        state_d = S_STABILIZE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        // Timeout: this attempt counts as failed.
                        retry_d = retry_inc;
                        cnt_d   = '0;
                        state_d = (retry_inc == RETRY_LIMIT) ? S_FAULT : S_PLL_RST;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                S_STABILIZE: begin
                    if (!lk_q) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                S_RUN: begin
                    if (!lk_q) begin
                        state_d = S_PLL_RST;
                        cnt_d   = '0;
                        retry_d = retry_inc;
                    end
                end
                S_FAULT: begin
                    state_d = S_FAULT;
                end
                default: begin
                    state_d = S_PLL_RST;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs decode the next state so they are registered yet valid on the first cycle of each state.
    always_comb begin
        pll_rst_d   = (state_d == S_PLL_RST) || (state_d == S_FAULT);
        ready_d     = (state_d == S_RUN);
        sys_rst_n_d = (state_d == S_RUN);
        fault_d     = (state_d == S_FAULT);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync1_q     <= 1'b0;
            lk_q        <= 1'b0;
            state_q     <= S_PLL_RST;
            cnt_q       <= '0;
            retry_q     <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            sync1_q     <= pll_locked;
            lk_q        <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_n_q <= sys_rst_n_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst_n = sys_rst_n_q;
    assign ready     = ready_q;
    assign fault     = fault_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with RST=4, STABLE=8, TIMEOUT=20, MAX_RETRIES=3.
// Expected values are queued as each step is driven and popped when the measurement completes.
module tb_pll_lock_sequencer;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       pll_locked = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       fault;
    logic [3:0] retry_cnt;

    pll_lock_sequencer #(
        .RST_CYCLES    (4),
        .STABLE_CYCLES (8),
        .TIMEOUT_CYCLES(20),
        .MAX_RETRIES   (3)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .pll_locked(pll_locked),
        .relock_req(relock_req),
        .pll_rst   (pll_rst),
        .sys_rst_n (sys_rst_n),
        .ready     (ready),
        .fault     (fault),
        .retry_cnt (retry_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    exp;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic push(input string tag, input int exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic check(input int obs);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed=%0d expected=none", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp)
            else begin
                errors++;
                $error("FAIL %s: observed=%0d expected=%0d", e.tag, obs, e.exp);
            end
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return pll_rst;
            1:       return ready;
            2:       return fault;
            default: return sys_rst_n;
        endcase
    endfunction

    // Counts rising edges until the selected output reads val; gives up after limit edges.
    task automatic count_until(input int sel, input logic val, input int limit, output int n);
        n = 0;
        while (sig(sel) !== val && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        int n;
        int hi;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        push("rst_pll_rst", 1);   check(int'(pll_rst));
        push("rst_sys_rst_n", 0); check(int'(sys_rst_n));
        push("rst_ready", 0);     check(int'(ready));
        push("rst_fault", 0);     check(int'(fault));
        push("rst_retry", 0);     check(int'(retry_cnt));

        // Nominal lock
        pll_locked = 1'b1;
        @(negedge clk);
        nrst = 1'b1;
        push("nom_pll_rst_len", 4);   count_until(0, 1'b0, 50, n); check(n);
        push("nom_ready_delay", 9);   count_until(1, 1'b1, 50, n); check(n);
        push("nom_sys_rst_n", 1);     check(int'(sys_rst_n));
        push("nom_retry", 0);         check(int'(retry_cnt));

        // Lock loss in RUN
        pll_locked = 1'b0;
        push("loss_ready_drop", 3);   count_until(1, 1'b0, 20, n); check(n);
        pll_locked = 1'b1;
        push("loss_sys_rst_n", 0);    check(int'(sys_rst_n));
        push("loss_retry", 1);        check(int'(retry_cnt));
        push("loss_pll_rst_len", 4);  count_until(0, 1'b0, 50, n); check(n);
        push("loss_ready_again", 9);  count_until(1, 1'b1, 50, n); check(n);
        push("loss_retry_run", 1);    check(int'(retry_cnt));

        // Relock then glitch during stabilization
        relock_req = 1'b1;
        @(posedge clk);
        #1;
        relock_req = 1'b0;
        push("relock_ready", 0);      check(int'(ready));
        push("relock_retry", 0);      check(int'(retry_cnt));
        push("glitch_pll_rst_len", 4); count_until(0, 1'b0, 50, n); check(n);
        n = 0;
        hi = 0;
        while (ready !== 1'b1 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 4) pll_locked = 1'b0;
            if (n == 5) pll_locked = 1'b1;
            if (pll_rst === 1'b1) hi++;
        end
        push("glitch_ready_delay", 16); check(n);
        push("glitch_no_pll_rst", 0);   check(hi);
        push("glitch_retry", 0);        check(int'(retry_cnt));

        // Asynchronous reset while in RUN, checked before the next rising edge
        @(negedge clk);
        #2;
        nrst = 1'b0;
        #1;
        push("async_pll_rst", 1);     check(int'(pll_rst));
        push("async_sys_rst_n", 0);   check(int'(sys_rst_n));
        push("async_ready", 0);       check(int'(ready));

        // Never locks: three timeouts then sticky fault
        pll_locked = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push($sformatf("nolock_rst_len%0d", i), 4);  count_until(0, 1'b0, 50, n); check(n);
            push($sformatf("nolock_wait_len%0d", i), 20); count_until(0, 1'b1, 50, n); check(n);
            push($sformatf("nolock_retry%0d", i), i + 1); check(int'(retry_cnt));
        end
        push("fault_set", 1);         check(int'(fault));
        n = 0;
        for (int c = 0; c < 250; c++) begin
            @(posedge clk);
            #1;
            if (fault !== 1'b1 || ready !== 1'b0 || pll_rst !== 1'b1) n++;
        end
        push("fault_sticky_bad_cycles", 0); check(n);

        // Recovery from FAULT
        pll_locked = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        relock_req = 1'b1;
        @(posedge clk);
        #1;
        relock_req = 1'b0;
        push("recover_fault", 0);     check(int'(fault));
        push("recover_retry", 0);     check(int'(retry_cnt));
        push("recover_pll_rst_len", 4); count_until(0, 1'b0, 50, n); check(n);
        push("recover_ready_delay", 9); count_until(1, 1'b1, 50, n); check(n);
        push("recover_sys_rst_n", 1); check(int'(sys_rst_n));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 The block SHALL have parameter RST_CYCLES, default 16, meaning the number of cycles pll_rst is held high per attempt (legal range 1..255).
REQ-002 The block SHALL have parameter STABLE_CYCLES, default 1024, meaning the number of consecutive synchronized-locked cycles required before ready (legal range 1..65535).
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 65535, meaning the maximum number of cycles spent waiting for lock per attempt (legal range 1..65535).
REQ-004 The block SHALL have parameter MAX_RETRIES, default 3, meaning the number of failed attempts tolerated before fault (legal range 1..15).
REQ-005 Port clk, input, 1 bit: free-running 50 MHz reference clock, the same net that drives the PLL refclk; the block's only clock.
REQ-006 Port nrst, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port pll_locked, input, 1 bit: PLL locked indicator, asynchronous to clk.
REQ-008 Port relock_req, input, 1 bit: single-cycle software request to re-run the lock sequence.
REQ-009 Port pll_rst, output, 1 bit: active-high reset to the PLL.
REQ-010 Port sys_rst_n, output, 1 bit: active-low reset for logic clocked by the PLL output.
REQ-011 Port ready, output, 1 bit: high when the PLL is stably locked.
REQ-012 Port fault, output, 1 bit: high when the retry budget is exhausted.
REQ-013 Port retry_cnt, output, 4 bits: number of failed attempts since the last reset or relock.

Function
REQ-014 pll_locked SHALL pass through a 2-flop synchronizer before any use; the synchronized value is called lk, and it lags pll_locked by 2 cycles.
REQ-015 The FSM SHALL have exactly 5 states: PLL_RST, WAIT_LOCK, STABILIZE, RUN, FAULT.
REQ-016 In PLL_RST, pll_rst SHALL be 1; after exactly RST_CYCLES cycles in this state the FSM SHALL go to WAIT_LOCK with the cycle counter cleared.
REQ-017 In WAIT_LOCK, lk=1 SHALL cause a transition to STABILIZE with the counter cleared.
REQ-018 In WAIT_LOCK, if the counter reaches TIMEOUT_CYCLES with lk=0, the block SHALL increment retry_cnt and go to PLL_RST, or go to FAULT if the incremented value equals MAX_RETRIES.
REQ-019 In STABILIZE, the counter SHALL increment while lk=1; lk=0 SHALL return the FSM to WAIT_LOCK with the counter cleared and retry_cnt unchanged.
REQ-020 STABILIZE SHALL go to RUN when the counter reaches STABLE_CYCLES.
REQ-021 In RUN, ready and sys_rst_n SHALL be 1; both SHALL be registered and assert on the first cycle in RUN.
REQ-022 In RUN, lk=0 SHALL deassert ready and sys_rst_n on the next cycle, increment retry_cnt (saturating at 15), and go to PLL_RST.
REQ-023 FAULT SHALL be sticky: pll_rst=1, sys_rst_n=0, ready=0, fault=1, and the state is left only via nrst or relock_req.
REQ-024 relock_req=1 in any state SHALL go to PLL_RST, clear retry_cnt and the counter, and deassert ready, sys_rst_n, and fault on the next cycle; relock_req SHALL take priority over all other transitions in the same cycle.
REQ-025 In every state other than RUN, sys_rst_n SHALL be 0 and ready SHALL be 0.
REQ-026 The counter SHALL be 16 bits wide and SHALL never wrap; every exit condition is evaluated before the counter could overflow.
REQ-027 All outputs SHALL be registered with no combinational paths from inputs to outputs.

Reset
REQ-028 While nrst=0, all state SHALL be cleared asynchronously: FSM=PLL_RST, counter=0, retry_cnt=0, synchronizer flops=0, pll_rst=1, sys_rst_n=0, ready=0, fault=0.
REQ-029 After nrst deasserts, the sequence SHALL begin at PLL_RST at the next rising edge of clk.
REQ-030 nrst asserted mid-sequence, including in RUN, SHALL immediately force the values of REQ-028.

Verification (RST_CYCLES=4, STABLE_CYCLES=8, TIMEOUT_CYCLES=20, MAX_RETRIES=3)
REQ-031 Nominal: release nrst, hold pll_locked=1 from cycle 0 -> pll_rst high for 4 cycles, then ready and sys_rst_n rise 2+8 cycles after WAIT_LOCK entry (within ±1 cycle for the synchronizer), retry_cnt=0.
REQ-032 Never locks: pll_locked=0 -> 3 timeouts of 20 cycles, each preceded by a 4-cycle pll_rst pulse; retry_cnt goes 1, 2, 3; fault=1 and stays 1 for more than 200 cycles.
REQ-033 Glitch in STABILIZE: a 1-cycle pll_locked=0 glitch at stabilize count 5 -> return to WAIT_LOCK, then a full 8-cycle stabilize, no pll_rst pulse, retry_cnt=0.
REQ-034 Lock loss in RUN: drop pll_locked -> ready=0 within 3 cycles, pll_rst pulses 4 cycles, retry_cnt=1, and the block re-reaches RUN once lock returns.
REQ-035 Recovery from FAULT: relock_req pulse in FAULT with pll_locked=1 -> fault=0 and retry_cnt=0 next cycle, then the nominal sequence leads to ready=1.
REQ-036 Async reset in RUN: assert nrst asynchronously between clock edges -> pll_rst=1, sys_rst_n=0, ready=0 before the next edge.
